// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM state encoding and
// an elaboration-time clog2 helper.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester found
// after last_owner, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  int unsigned idx;

  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_owner) + k) % NUM_REQ;
      if (!pick_vld && req[IDX_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded burst tenures and write gating on fifo_full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_data,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner
);

  localparam int                CNT_W      = clog2(MAX_BURST) + 1;
  localparam logic [IDX_W-1:0]  OWNER_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   burst_q, burst_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               owner_req;
  logic [WIDTH-1:0]   owner_word;
  logic               wr_en;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .pick_idx   (pick_idx),
    .pick_vld   (pick_vld)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req  = req[i];
        owner_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs are forced quiet while reset is high, even mid-burst.
  always_comb begin
    wr_en      = (state_q == ST_GRANT) && owner_req && !fifo_full && !reset;
    gnt        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt[i] = wr_en && (owner_q == IDX_W'(i));
    end
    fifo_write = wr_en;
    fifo_data  = wr_en ? owner_word : '0;
    busy       = (state_q == ST_GRANT) && !reset;
    owner      = owner_q;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (!fifo_full) begin
          burst_d = burst_q + 1'b1;
          if (burst_q == BURST_LAST) begin
            state_d = ST_IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_RST;
      last_q  <= OWNER_RST;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a small FIFO
// model that holds CAP words and raises full at CAP.
module tb_fifo_wr_arbiter;

  localparam int CAP = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data;
  logic        busy;
  logic [1:0]  owner;

  int total = 0;
  int bad = 0;
  int overflow_seen = 0;

  logic [7:0] fifo_q[$];
  bit         model_on;
  bit         force_full;
  bit         rd_en;
  bit         pop_vld;
  logic [7:0] pop_word;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .owner      (owner)
  );

  function automatic void upd_full();
    fifo_full = force_full || (model_on && fifo_q.size() >= CAP);
  endfunction

  // Captures pre-edge write, advances one clock, then updates the FIFO model.
  task automatic adv();
    logic       w;
    logic [7:0] d;
    w = fifo_write;
    d = fifo_data;
    @(posedge clk);
    #1;
    pop_vld = 1'b0;
    if (model_on) begin
      if (w && fifo_q.size() >= CAP) overflow_seen++;
      if (rd_en && fifo_q.size() > 0) begin
        pop_word = fifo_q.pop_front();
        pop_vld  = 1'b1;
      end
      if (w && fifo_q.size() < CAP) fifo_q.push_back(d);
    end
    upd_full();
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; req_data = '0; rd_en = 1'b0;
    force_full = 1'b0; model_on = 1'b0;
    fifo_q.delete();
    upd_full();
    adv();
    adv();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = 32'hFFFF_FFFF;
    adv(); adv();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    total++; if (fifo_write !== 1'b0) begin bad++; $display("FAIL reset_write: got %b want 0", fifo_write); end
    total++; if (fifo_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", fifo_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL reset_owner: got %0d want 3", owner); end
    req = '0; req_data = '0;
    reset = 1'b0;
  endtask

  task automatic test_single_port();
    logic [7:0] pat;
    logic [7:0] d;
    logic [7:0] exp_d;
    apply_reset();
    model_on = 1'b1; upd_full();
    pat = 8'b0111_1011;
    d = 8'h10;
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      req_data[7:0] = d;
      #1;
      exp_d = pat[7-c] ? d : 8'h00;
      total++; if (gnt !== {3'b000, pat[7-c]}) begin bad++; $display("FAIL single_gnt c%0d: got %b want %b", c+1, gnt, {3'b000, pat[7-c]}); end
      total++; if (fifo_data !== exp_d) begin bad++; $display("FAIL single_data c%0d: got %h want %h", c+1, fifo_data, exp_d); end
      if (pat[7-c]) d = d + 8'h01;
      adv();
    end
    req = '0;
    #1; adv();
    total++; if (fifo_q.size() != 6) begin bad++; $display("FAIL single_count: got %0d want 6", fifo_q.size()); end
    for (int i = 0; i < 6 && i < fifo_q.size(); i++) begin
      total++; if (fifo_q[i] !== 8'(8'h10 + i)) begin bad++; $display("FAIL single_word%0d: got %h want %h", i, fifo_q[i], 8'(8'h10 + i)); end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expg;
    int p;
    apply_reset();
    req = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 25; k++) begin
      #1;
      p = (k / 5) % 4;
      expg = (k % 5 == 0) ? 4'b0000 : 4'(4'b0001 << p);
      total++; if (gnt !== expg) begin bad++; $display("FAIL rr_gnt k%0d: got %b want %b", k, gnt, expg); end
      if (k % 5 != 0) begin
        total++; if (owner !== 2'(p)) begin bad++; $display("FAIL rr_owner k%0d: got %0d want %0d", k, owner, p); end
        total++; if (fifo_data !== 8'(8'hA0 + p)) begin bad++; $display("FAIL rr_data k%0d: got %h want %h", k, fifo_data, 8'(8'hA0 + p)); end
      end
      adv();
    end
    req = '0;
  endtask

  task automatic test_full_stall();
    logic [8:0] wtab;
    logic [8:0] rtab;
    logic [8:0] btab;
    logic [7:0] d;
    logic [7:0] exp_d;
    apply_reset();
    model_on = 1'b1;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hEE);
    upd_full();
    wtab = 9'b011000110;
    rtab = 9'b000001100;
    btab = 9'b011111110;
    d = 8'h30;
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      rd_en = rtab[8-c];
      req_data[7:0] = d;
      #1;
      exp_d = wtab[8-c] ? d : 8'h00;
      total++; if (fifo_write !== wtab[8-c]) begin bad++; $display("FAIL stall_write c%0d: got %b want %b", c+1, fifo_write, wtab[8-c]); end
      total++; if (busy !== btab[8-c]) begin bad++; $display("FAIL stall_busy c%0d: got %b want %b", c+1, busy, btab[8-c]); end
      total++; if (fifo_data !== exp_d) begin bad++; $display("FAIL stall_data c%0d: got %h want %h", c+1, fifo_data, exp_d); end
      if (c >= 3 && c <= 5) begin
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL stall_owner c%0d: got %0d want 0", c+1, owner); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL stall_gnt c%0d: got %b want 0000", c+1, gnt); end
      end
      if (wtab[8-c]) d = d + 8'h01;
      adv();
    end
    rd_en = 1'b0; req = '0;
    total++; if (overflow_seen != 0) begin bad++; $display("FAIL stall_overflow: got %0d want 0", overflow_seen); end
    total++; if (fifo_q.size() != 7 || fifo_q[6] !== 8'h33) begin bad++; $display("FAIL stall_tail: got size %0d want 7 ending 33", fifo_q.size()); end
  endtask

  task automatic test_early_release();
    apply_reset();
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req = 4'b0100;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL early_arb: got %b want 0000", gnt); end
    adv();
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL early_gnt%0d: got %b want 0100", c, gnt); end
      adv();
    end
    req = 4'b1001;
    #1;
    total++; if (gnt !== 4'b0000 || fifo_write !== 1'b0) begin bad++; $display("FAIL early_drop: got gnt %b wr %b want 0000 0", gnt, fifo_write); end
    adv();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL early_idle: got busy %b want 0", busy); end
    adv();
    #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL early_next_gnt: got %b want 1000", gnt); end
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL early_next_owner: got %0d want 3", owner); end
    total++; if (fifo_data !== 8'hD3) begin bad++; $display("FAIL early_next_data: got %h want d3", fifo_data); end
    adv();
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    req = 4'b0010;
    #1; adv();
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rmb_first: got %b want 0010", gnt); end
    adv();
    reset = 1'b1;
    #1;
    total++; if (fifo_write !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL rmb_suppress: got wr %b gnt %b want 0 0000", fifo_write, gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmb_busy_rst: got %b want 0", busy); end
    adv();
    reset = 1'b0;
    req = 4'b1111;
    #1;
    total++; if (busy !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL rmb_after: got busy %b gnt %b want 0 0000", busy, gnt); end
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL rmb_owner_rst: got %0d want 3", owner); end
    adv();
    #1;
    total++; if (gnt !== 4'b0001 || owner !== 2'd0) begin bad++; $display("FAIL rmb_next: got gnt %b owner %0d want 0001 0", gnt, owner); end
    adv();
    req = '0;
  endtask

  task automatic test_random();
    logic [5:0] pseq[4];
    logic [5:0] rseq[4];
    logic [3:0] g;
    logic [3:0] last_g;
    logic [1:0] port;
    apply_reset();
    model_on = 1'b1; upd_full();
    for (int i = 0; i < 4; i++) begin pseq[i] = '0; rseq[i] = '0; end
    last_g = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
        else if (last_g[i] && $urandom_range(0, 3) == 0) req[i] = 1'b0;
        req_data[i*8 +: 8] = {2'(i), pseq[i]};
      end
      rd_en = ($urandom_range(0, 1) == 1);
      #1;
      g = gnt;
      total++; if ((g & (g - 4'd1)) !== 4'b0000 || (g & ~req) !== 4'b0000) begin bad++; $display("FAIL rnd_gnt_legal cyc%0d: got gnt %b req %b", cyc, g, req); end
      total++; if (fifo_write !== (g != 4'b0000)) begin bad++; $display("FAIL rnd_write cyc%0d: got %b want %b", cyc, fifo_write, (g != 4'b0000)); end
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL rnd_full_gate cyc%0d: gnt %b while full", cyc, g); end
          total++; if (fifo_data !== {2'(i), pseq[i]}) begin bad++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, fifo_data, {2'(i), pseq[i]}); end
          pseq[i] = pseq[i] + 6'd1;
        end
      end
      last_g = g;
      adv();
      if (pop_vld) begin
        port = pop_word[7:6];
        total++; if (pop_word[5:0] !== rseq[port]) begin bad++; $display("FAIL rnd_order port%0d: got seq %0d want %0d", port, pop_word[5:0], rseq[port]); end
        rseq[port] = rseq[port] + 6'd1;
      end
    end
    req = '0; rd_en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1; adv();
      if (pop_vld) begin
        port = pop_word[7:6];
        total++; if (pop_word[5:0] !== rseq[port]) begin bad++; $display("FAIL rnd_drain port%0d: got seq %0d want %0d", port, pop_word[5:0], rseq[port]); end
        rseq[port] = rseq[port] + 6'd1;
      end
    end
    rd_en = 1'b0;
    total++; if (fifo_q.size() != 0) begin bad++; $display("FAIL rnd_empty: got %0d want 0", fifo_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rseq[i] !== pseq[i]) begin bad++; $display("FAIL rnd_loss port%0d: got %0d read want %0d written", i, rseq[i], pseq[i]); end
    end
    total++; if (overflow_seen != 0) begin bad++; $display("FAIL rnd_overflow: got %0d want 0", overflow_seen); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; rd_en = 1'b0;
    force_full = 1'b0; model_on = 1'b0; pop_vld = 1'b0; pop_word = '0;
    upd_full();
    test_reset();
    test_single_port();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
